// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage with one outstanding ibus request and a
// one-entry output register toward pre-decode.
package inst_fetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fsm_t;

  fsm_t        fsm;
  fsm_t        fsm_nx;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        discard;
  logic        held;
  logic        consume;
  logic        fire;
  logic        resp;
  logic        load;

  assign held    = inst_valid && stall;
  assign consume = inst_valid && !stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm <= S_REQ;
    end else begin
      fsm <= fsm_nx;
    end
  end

  always_comb begin
    fsm_nx = fsm;
    unique case (fsm)
      S_REQ:  if (fire) fsm_nx = S_WAIT;
      S_WAIT: if (iresp.data_ok) fsm_nx = S_REQ;
      default: fsm_nx = S_REQ;
    endcase
  end

  always_comb begin
    ireq       = '0;
    ireq.addr  = pc;
    resp       = 1'b0;
    unique case (1'b1)
      (fsm == S_REQ):  ireq.valid = !held;
      (fsm == S_WAIT): resp = iresp.data_ok;
      default: ;
    endcase
    fire = ireq.valid && iresp.addr_ok;
    load = resp && !discard && !redirect_valid;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc      <= RESET_PC;
      req_pc  <= '0;
      discard <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (fire) begin
        pc <= pc + 32'd4;
      end
      if (fire) begin
        req_pc <= pc;
      end
      // A redirect marks the request still on the bus as stale.
      if (resp) begin
        discard <= 1'b0;
      end else if (redirect_valid
                   && (fire || fsm == S_WAIT)) begin
        discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      if (redirect_valid) begin
        inst_valid <= 1'b0;
      end else if (load) begin
        inst_valid <= 1'b1;
        inst       <= iresp.data;
        inst_pc    <= req_pc;
      end else if (consume) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed redirect/stall/wrap scenarios against an
// ibus model; a scoreboard checks accepted requests and consumed words.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic        aok;
  logic        dok = 1'b0;
  logic        bus_pend = 1'b0;
  logic [31:0] bus_addr = '0;
  int          bus_cnt = 0;
  int          dly;

  logic [31:0] req_q[$];
  logic [63:0] exp_q[$];
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  assign iresp = {aok, dok, bus_addr + 32'h1000_0001};

  inst_fetch dut (
    .clk(clk),
    .resetn(resetn),
    .ireq(ireq),
    .iresp(iresp),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc)
  );

  // ibus model: data_ok dly+1 cycles after addr_ok, data = addr+0x10000001
  always @(posedge clk) begin
    if (!resetn) begin
      bus_pend = 1'b0;
      bus_cnt  = 0;
      #1;
      dok = 1'b0;
    end else begin
      if (dok) bus_pend = 1'b0;
      if (ireq.valid && aok) begin
        bus_pend = 1'b1;
        bus_addr = ireq.addr;
        bus_cnt  = dly;
      end else if (bus_pend && bus_cnt > 0) begin
        bus_cnt = bus_cnt - 1;
      end
      #1;
      dok = bus_pend && bus_cnt == 0;
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (ireq.valid && aok) begin
        if (req_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL req_extra: got %h expected none",
                   ireq.addr);
        end else begin
          check("req_addr", ireq.addr, req_q.pop_front());
        end
      end
      if (inst_valid && !stall) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL inst_extra: got pc %h expected none",
                   inst_pc);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e[63:32]);
          check("inst", inst, e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic rst();
    resetn         = 1'b0;
    aok            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dly            = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic redir(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn         = 1'b0;
    aok            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dly            = 0;
    @(negedge clk);
    check("rst_req_valid", 32'(ireq.valid), 32'd1);
    check("rst_req_addr", ireq.addr, 32'hBFC0_0000);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // reset fetch, then stall while 0xBFC00008 is held
    req_q = '{32'hBFC0_0000, 32'hBFC0_0004,
              32'hBFC0_0008, 32'hBFC0_000C};
    exp_q = '{{32'hBFC0_0000, 32'hCFC0_0001},
              {32'hBFC0_0004, 32'hCFC0_0005},
              {32'hBFC0_0008, 32'hCFC0_0009},
              {32'hBFC0_000C, 32'hCFC0_000D}};
    rst();
    aok = 1'b1;
    steps(6);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_pc", inst_pc, 32'hBFC0_0008);
      check("stall_inst", inst, 32'hCFC0_0009);
      check("stall_req", 32'(ireq.valid), 32'd0);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    check("release_req", 32'(ireq.valid), 32'd1);
    check("release_addr", ireq.addr, 32'hBFC0_000C);
    step();
    aok = 1'b0;
    steps(3);

    // redirect while waiting on 0xBFC00008
    req_q = '{32'hBFC0_0000, 32'hBFC0_0004,
              32'hBFC0_0008, 32'h8000_1000};
    exp_q = '{{32'hBFC0_0000, 32'hCFC0_0001},
              {32'hBFC0_0004, 32'hCFC0_0005},
              {32'h8000_1000, 32'h9000_1001}};
    rst();
    aok = 1'b1;
    steps(4);
    dly = 2;
    step();
    redir(32'h8000_1000);
    step();
    redirect_valid = 1'b0;
    dly = 0;
    steps(2);
    @(negedge clk);
    check("wait_redir_valid", 32'(ireq.valid), 32'd1);
    check("wait_redir_addr", ireq.addr, 32'h8000_1000);
    step();
    aok = 1'b0;
    steps(3);

    // redirect on the addr_ok handshake for 0xBFC00004
    req_q = '{32'hBFC0_0000, 32'hBFC0_0004, 32'h8000_2000};
    exp_q = '{{32'hBFC0_0000, 32'hCFC0_0001},
              {32'h8000_2000, 32'h9000_2001}};
    rst();
    aok = 1'b1;
    steps(2);
    redir(32'h8000_2000);
    step();
    redirect_valid = 1'b0;
    step();
    @(negedge clk);
    check("hs_redir_valid", 32'(ireq.valid), 32'd1);
    check("hs_redir_addr", ireq.addr, 32'h8000_2000);
    step();
    aok = 1'b0;
    steps(3);

    // flush of a stalled word, then redirect alongside data_ok
    req_q = '{32'hBFC0_0000, 32'h8000_3000, 32'h8000_4000};
    exp_q = '{{32'h8000_4000, 32'h9000_4001}};
    rst();
    aok = 1'b1;
    steps(2);
    stall = 1'b1;
    step();
    redir(32'h8000_3000);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(inst_valid), 32'd0);
    check("flush_req", 32'(ireq.valid), 32'd1);
    check("flush_addr", ireq.addr, 32'h8000_3000);
    step();
    redir(32'h8000_4000);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("dok_redir_ivalid", 32'(inst_valid), 32'd0);
    check("dok_redir_req", 32'(ireq.valid), 32'd1);
    check("dok_redir_addr", ireq.addr, 32'h8000_4000);
    step();
    aok = 1'b0;
    step();
    stall = 1'b0;
    steps(2);

    // wrap past 0xFFFFFFFC, then async reset mid-wait
    req_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    exp_q = '{{32'hFFFF_FFFC, 32'h0FFF_FFFD}};
    rst();
    redir(32'hFFFF_FFFC);
    step();
    redirect_valid = 1'b0;
    aok = 1'b1;
    @(negedge clk);
    check("unacc_redir_addr", ireq.addr, 32'hFFFF_FFFC);
    steps(2);
    dly = 3;
    @(negedge clk);
    check("wrap_addr", ireq.addr, 32'h0000_0000);
    step();
    aok = 1'b0;
    check("pre_rst_req", 32'(ireq.valid), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_req_valid", 32'(ireq.valid), 32'd1);
    check("arst_req_addr", ireq.addr, 32'hBFC0_0000);
    check("arst_inst_valid", 32'(inst_valid), 32'd0);
    check("arst_inst", inst, 32'h0);
    check("arst_inst_pc", inst_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    steps(2);

    check("req_q_left", 32'(req_q.size()), 32'd0);
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
